alu_bit_serial_seq: RTL and testbench
=====================================

Name: alu_bit_serial_seq

Overview:
- Bit-serial sequencer that sits directly in front of and behind the calculator's 1-bit ALU slice.
- Accepts a full-width operand pair plus a 3-bit ALU control code through a valid/ready handshake.
- Drives the slice one bit per cycle, LSB first, and registers the slice carry between bits.
- Collects the result bits and presents the full-width result with flags through a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_a  input  WIDTH  operand A, sampled on accept.
- op_b  input  WIDTH  operand B, sampled on accept.
- op_ctrl  input  3  ALU control: 2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR; 0 and 1 are illegal.
- start_valid  input  1  request valid.
- start_ready  output  1  high only in IDLE.
- slice_a  output  1  current bit of A to the slice.
- slice_b  output  1  current bit of B to the slice.
- slice_cin  output  1  carry into the slice for the current bit.
- slice_ctrl  output  3  latched control code to the slice.
- slice_out  input  1  slice result bit; combinational from the slice_* outputs.
- slice_cout  input  1  slice carry out.
- result  output  WIDTH  assembled result.
- carry  output  1  carry out of the MSB; arithmetic ops only, else 0.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB); arithmetic ops only, else 0.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- err  output  1  illegal op_ctrl was accepted.
- result_valid  output  1  result and flags valid.
- result_ready  input  1  consumer accepts result.

Behaviour:
- Reset: state=IDLE; start_ready=1 on the cycle after reset deasserts.
  - result, carry, overflow, zero, negative, err, result_valid all 0.
  - slice_a, slice_b, slice_cin, slice_ctrl all 0.
  - Internal bit counter 0.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid=1:
  - Latch op_a, op_b, op_ctrl into shift registers.
  - Carry register = 1 if op_ctrl==3, else 0.
  - Counter = 0.
  - op_ctrl in 2..7 -> RUN.
  - op_ctrl in 0..1 -> DONE with result=0, err=1, all other flags 0.
- RUN: start_ready=0.
  - slice_a/slice_b = bit[counter] of the latched operands (LSB of the shift registers).
  - slice_cin = carry register; slice_ctrl = latched code.
  - Each cycle:
    - Shift slice_out into the result register MSB and shift right.
    - Carry register <= slice_cout; the previous carry register value is kept as the MSB carry-in for the overflow computation.
    - counter++.
  - When counter==WIDTH-1 is processed -> DONE.
  - RUN lasts exactly WIDTH cycles.
- Entering DONE:
  - carry = final slice_cout if arithmetic, else 0.
  - overflow = MSB carry-in XOR MSB carry-out if arithmetic, else 0.
  - zero and negative are computed from the final result.
  - err=0.
- DONE: result_valid=1. result and flags hold stable until result_ready=1, then -> IDLE and result_valid drops the next cycle. Outputs retain their values in IDLE until the next DONE.
- Latency: the accept edge is cycle 0; result_valid rises at cycle WIDTH+1 for legal ops and at cycle 1 for illegal ops.
- Throughput: at most one op per WIDTH+2 cycles. No back-to-back accept: start_ready is low in DONE even when result_ready=1.
- start_valid outside IDLE is ignored; the inputs are not sampled.
- Reset has priority over all transitions. Reset mid-RUN or mid-DONE discards the operation and returns to reset values the next cycle; no result is emitted.
- In IDLE/DONE, slice_* outputs are driven 0; the slice result is ignored.
- Wrap-around: arithmetic is modulo 2^WIDTH.
- SUB computes A + ~B + 1; the ~B is done by the slice via ctrl[0]. carry=1 means no borrow.

Test Plan:
- ADD, WIDTH=32: A=0xFFFFFFFF, B=0x00000001, ctrl=2 -> result=0x00000000, carry=1, zero=1, overflow=0, negative=0; result_valid at cycle 33.
- SUB: A=0x00000005, B=0x00000007, ctrl=3 -> result=0xFFFFFFFE, carry=0, negative=1, overflow=0.
- ADD overflow: A=0x7FFFFFFF, B=0x00000001, ctrl=2 -> result=0x80000000, overflow=1, carry=0, negative=1.
- Logic ops on A=0xF0F0F0F0, B=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - NOR -> 0x000F000F.
  - XOR -> 0x0FF00FF0.
  - carry=0 and overflow=0 for all four.
- Illegal and backpressure: ctrl=1 -> result_valid at cycle 1, err=1, result=0. Hold result_ready=0 for 5 cycles -> outputs stable and start_ready=0 throughout; a start_valid pulse during the hold is ignored.
- Reset mid-RUN: assert reset at cycle 10 of an ADD -> next cycle result_valid=0, start_ready=1, flags 0. A new ADD 3+4 then yields 7.

Source files
------------

// File: rtl/alu_bit_serial_seq_if.sv
// Request, 1-bit ALU slice and result signals of the bit-serial sequencer.
// The master is the surrounding environment; the slave is the sequencer.
interface alu_bit_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_ctrl;
  logic             start_valid;
  logic             start_ready;

  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [2:0]       slice_ctrl;
  logic             slice_out;
  logic             slice_cout;

  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             err;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output op_a, op_b, op_ctrl, start_valid, slice_out, slice_cout, result_ready,
    input  start_ready, slice_a, slice_b, slice_cin, slice_ctrl,
           result, carry, overflow, zero, negative, err, result_valid
  );

  modport slave (
    input  op_a, op_b, op_ctrl, start_valid, slice_out, slice_cout, result_ready,
    output start_ready, slice_a, slice_b, slice_cin, slice_ctrl,
           result, carry, overflow, zero, negative, err, result_valid
  );
endinterface

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice; result_valid WIDTH+1 cycles after accept (1 for illegal ops).
// One op in flight: start_ready only in IDLE, result and flags held until result_ready.
module alu_bit_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_bit_serial_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;
  logic             arith;
  logic             last_bit;
  logic             ctrl_legal;

  assign arith      = (ctrl_q[2:1] == 2'b01);
  assign last_bit   = (cnt_q == CW'(WIDTH - 1));
  assign ctrl_legal = (bus.op_ctrl[2:1] != 2'b00);

  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_d              = b_q;
    res_d            = res_q;
    ctrl_d           = ctrl_q;
    cnt_d            = cnt_q;
    cy_d             = cy_q;
    carry_d          = carry_q;
    ovf_d            = ovf_q;
    zero_d           = zero_q;
    neg_d            = neg_q;
    err_d            = err_q;
    bus.start_ready  = 1'b0;
    bus.result_valid = 1'b0;
    bus.slice_a      = 1'b0;
    bus.slice_b      = 1'b0;
    bus.slice_cin    = 1'b0;
    bus.slice_ctrl   = 3'd0;

    unique case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          a_d    = bus.op_a;
          b_d    = bus.op_b;
          ctrl_d = bus.op_ctrl;
          cy_d   = (bus.op_ctrl == 3'd3);
          cnt_d  = '0;
          if (ctrl_legal) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            res_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
            neg_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end

      RUN: begin
        bus.slice_a    = a_q[0];
        bus.slice_b    = b_q[0];
        bus.slice_cin  = cy_q;
        bus.slice_ctrl = ctrl_q;
        // Result bits fill the MSBs vacated by A, so A ends up holding the result.
        a_d   = {bus.slice_out, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cy_d  = bus.slice_cout;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = DONE;
          res_d   = a_d;
          carry_d = arith & bus.slice_cout;
          ovf_d   = arith & (cy_q ^ bus.slice_cout);
          zero_d  = (a_d == '0);
          neg_d   = bus.slice_out;
          err_d   = 1'b0;
        end
      end

      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ctrl_q  <= 3'd0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign bus.result   = res_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Randomized bench for alu_bit_serial_seq with a behavioural 1-bit slice and a word-level reference model.
module tb_alu_bit_serial_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_bit_serial_seq_if #(.WIDTH(W)) bus();

  alu_bit_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Slice: logic ops report a junk carry so the sequencer must mask it.
  logic s_out, s_cout, s_bx;
  always_comb begin
    s_bx   = bus.slice_b ^ bus.slice_ctrl[0];
    s_out  = 1'b1;
    s_cout = 1'b1;
    case (bus.slice_ctrl)
      3'd2, 3'd3: begin
        s_out  = bus.slice_a ^ s_bx ^ bus.slice_cin;
        s_cout = (bus.slice_a & s_bx) | (bus.slice_a & bus.slice_cin) | (s_bx & bus.slice_cin);
      end
      3'd4: begin s_out = bus.slice_a & bus.slice_b;    s_cout = bus.slice_a | bus.slice_b; end
      3'd5: begin s_out = bus.slice_a | bus.slice_b;    s_cout = bus.slice_a | bus.slice_b; end
      3'd6: begin s_out = ~(bus.slice_a | bus.slice_b); s_cout = bus.slice_a | bus.slice_b; end
      3'd7: begin s_out = bus.slice_a ^ bus.slice_b;    s_cout = bus.slice_a | bus.slice_b; end
      default: ;
    endcase
  end
  assign bus.slice_out  = s_out;
  assign bus.slice_cout = s_cout;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctrl,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output logic z, output logic n, output logic e);
    logic [W:0] s;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    r = '0;
    case (ctrl)
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~(a | b);
      3'd7: r = a ^ b;
      default: e = 1'b1;
    endcase
    z = !e && (r == '0);
    n = r[W-1];
  endtask

  task automatic check_flags(input string pfx, input logic [W-1:0] er, input logic ec,
                             input logic ev, input logic ez, input logic en, input logic ee);
    chk({pfx, "_result"},   bus.result,   er);
    chk({pfx, "_carry"},    bus.carry,    ec);
    chk({pfx, "_overflow"}, bus.overflow, ev);
    chk({pfx, "_zero"},     bus.zero,     ez);
    chk({pfx, "_negative"}, bus.negative, en);
    chk({pfx, "_err"},      bus.err,      ee);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctrl,
                        input int hold, input bit pulse);
    logic [W-1:0] er;
    logic ec, ev, ez, en, ee;
    int lat;
    model(a, b, ctrl, er, ec, ev, ez, en, ee);
    @(negedge clk);
    chk("idle_ready", bus.start_ready, 1'b1);
    bus.op_a        = a;
    bus.op_b        = b;
    bus.op_ctrl     = ctrl;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.op_a        = $urandom;
    bus.op_b        = $urandom;
    if (ctrl >= 3'd2) begin
      chk("run_slice_ctrl", bus.slice_ctrl, ctrl);
      chk("run_slice_a0", bus.slice_a, a[0]);
      chk("run_not_ready", bus.start_ready, 1'b0);
    end
    lat = 1;
    while (!bus.result_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (ctrl >= 3'd2) ? W + 1 : 1);
    check_flags("done", er, ec, ev, ez, en, ee);
    bus.result_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.start_valid = 1'b1;
        bus.op_ctrl     = 3'($urandom_range(2, 7));
      end
      @(negedge clk);
      chk("hold_valid", bus.result_valid, 1'b1);
      chk("hold_not_ready", bus.start_ready, 1'b0);
      chk("hold_result", bus.result, er);
      chk("hold_err", bus.err, ee);
      chk("hold_slice_ctrl", bus.slice_ctrl, 3'd0);
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("release_valid", bus.result_valid, 1'b0);
    chk("release_ready", bus.start_ready, 1'b1);
    check_flags("retain", er, ec, ev, ez, en, ee);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc;

    reset            = 1'b1;
    bus.op_a         = '0;
    bus.op_b         = '0;
    bus.op_ctrl      = 3'd0;
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.start_ready, 1'b1);
    chk("rst_valid", bus.result_valid, 1'b0);
    check_flags("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_slice", {bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_ctrl}, 6'd0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 0, 1'b0);
    chk("add_wrap_const", bus.result, 32'h0);
    run_op(32'h0000_0005, 32'h0000_0007, 3'd3, 1, 1'b0);
    chk("sub_const", bus.result, 32'hFFFF_FFFE);
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 0, 1'b0);
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 0, 1'b0);
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 0, 1'b0);
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 0, 1'b0);
    chk("xor_const", bus.result, 32'h0FF0_0FF0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd1, 5, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd2, 2, 1'b1);
    chk("add_ovf_const", bus.result, 32'h8000_0000);

    // Reset sampled at cycle 10 of an ADD discards it and clears the previous flags.
    @(negedge clk);
    bus.op_a        = 32'h1111_1111;
    bus.op_b        = 32'h2222_2222;
    bus.op_ctrl     = 3'd2;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", bus.result_valid, 1'b0);
    chk("midrst_ready", bus.start_ready, 1'b1);
    check_flags("midrst", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_slice_ctrl", bus.slice_ctrl, 3'd0);
    run_op(32'd3, 32'd4, 3'd2, 0, 1'b0);
    chk("add_3_4", bus.result, 32'd7);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      rc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
